// File: rtl/alu_seq_param.sv
// Parametrised multi-cycle ALU: single-step ops finish on the accept edge, while MUL (shift-add)
// and DIVMOD (restoring divide) iterate one bit per cycle. Valid/ready on both sides.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   alu_out,
  output logic                 cout,
  output logic                 bout,
  output logic                 zero,
  output logic                 div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_DIV  = 4'h3,
    OP_SHL  = 4'h4, OP_SHR  = 4'h5, OP_ASR  = 4'h6, OP_NOT  = 4'h7,
    OP_OR   = 4'h8, OP_AND  = 4'h9, OP_XOR  = 4'hA, OP_NOR  = 4'hB,
    OP_NAND = 4'hC, OP_XNOR = 4'hD, OP_GT   = 4'hE, OP_EQ   = 4'hF
  } op_e;

  state_e               state_q, state_d;
  logic                 is_mul_q, is_mul_d;
  logic [WIDTH-1:0]     a_q, a_d;      // multiplier (MUL) or dividend shifting into quotient (DIVMOD)
  logic [WIDTH-1:0]     b_q, b_d;      // divisor
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [2*WIDTH-1:0]   sh_q, sh_d;    // multiplicand, shifted left each iteration
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 cout_q, cout_d, bout_q, bout_d, zero_q, zero_d, dz_q, dz_d;

  // Single-step datapath, evaluated directly from the input operands on the accept cycle.
  logic [WIDTH:0]       sum, diff;
  logic [2*WIDTH-1:0]   ss_res;
  logic                 ss_cout, ss_bout, ss_dz;

  function automatic logic [2*WIDTH-1:0] zext(input logic [WIDTH-1:0] v);
    return {{WIDTH{1'b0}}, v};
  endfunction

  assign sum  = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff = {1'b0, operand_a} - {1'b0, operand_b};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ss_res  = '0;
    ss_cout = 1'b0;
    ss_bout = 1'b0;
    ss_dz   = 1'b0;
    case (op_e'(opcode))
      OP_ADD:  begin ss_res = zext(sum[WIDTH-1:0]);  ss_cout = sum[WIDTH];  end
      OP_SUB:  begin ss_res = zext(diff[WIDTH-1:0]); ss_bout = diff[WIDTH]; end
      OP_DIV:  ss_dz = (operand_b == '0);
      OP_SHL:  ss_res = zext({operand_a[WIDTH-2:0], 1'b0});
      OP_SHR:  ss_res = zext({1'b0, operand_a[WIDTH-1:1]});
      OP_ASR:  ss_res = {{(WIDTH+1){operand_a[WIDTH-1]}}, operand_a[WIDTH-1:1]};
      OP_NOT:  ss_res = zext(~operand_a);
      OP_OR:   ss_res = zext(operand_a | operand_b);
      OP_AND:  ss_res = zext(operand_a & operand_b);
      OP_XOR:  ss_res = zext(operand_a ^ operand_b);
      OP_NOR:  ss_res = zext(~(operand_a | operand_b));
      OP_NAND: ss_res = zext(~(operand_a & operand_b));
      OP_XNOR: ss_res = zext(~(operand_a ^ operand_b));
      OP_GT:   ss_res = zext(WIDTH'(operand_a > operand_b));
      OP_EQ:   ss_res = zext(WIDTH'(operand_a == operand_b));
      default: ss_res = '0;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide.
  logic [2*WIDTH-1:0]   mul_acc_nx, fin_res;
  logic [WIDTH:0]       div_trial;
  logic                 div_fit;
  logic [WIDTH-1:0]     div_rem_nx, div_q_nx;

  assign mul_acc_nx = a_q[0] ? acc_q + sh_q : acc_q;
  assign div_trial  = {rem_q, a_q[WIDTH-1]} - {1'b0, b_q};
  assign div_fit    = ~div_trial[WIDTH];
  assign div_rem_nx = div_fit ? div_trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], a_q[WIDTH-1]};
  assign div_q_nx   = {a_q[WIDTH-2:0], div_fit};
  assign fin_res    = is_mul_q ? mul_acc_nx : {div_q_nx, div_rem_nx};

  always_comb begin
    state_d  = state_q;
    is_mul_d = is_mul_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    cout_d   = cout_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = operand_a;
          b_d   = operand_b;
          cnt_d = '0;
          if (op_e'(opcode) == OP_MUL) begin
            is_mul_d = 1'b1;
            sh_d     = zext(operand_b);
            acc_d    = '0;
            state_d  = S_EXEC;
          end else if (op_e'(opcode) == OP_DIV && operand_b != '0) begin
            is_mul_d = 1'b0;
            rem_d    = '0;
            state_d  = S_EXEC;
          end else begin
            res_d   = ss_res;
            cout_d  = ss_cout;
            bout_d  = ss_bout;
            dz_d    = ss_dz;
            zero_d  = (ss_res == '0);
            state_d = S_DONE;
          end
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + CW'(1);
        if (is_mul_q) begin
          acc_d = mul_acc_nx;
          sh_d  = {sh_q[2*WIDTH-2:0], 1'b0};
          a_d   = {1'b0, a_q[WIDTH-1:1]};
        end else begin
          rem_d = div_rem_nx;
          a_d   = div_q_nx;
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d   = fin_res;
          cout_d  = 1'b0;
          bout_d  = 1'b0;
          dz_d    = 1'b0;
          zero_d  = (fin_res == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      is_mul_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      sh_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_mul_q <= is_mul_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      cout_q   <= cout_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      dz_q     <= dz_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign alu_out   = res_q;
  assign cout      = cout_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign div_zero  = dz_q;

endmodule
